// File: rtl/rgbw_frame_parser.sv
// rgbw_frame_parser: hunts for a sync byte in the SPI byte stream, collects a
// payload frame with optional XOR checksum, and commits good frames atomically
// to ch_out. Partial frames are dropped on checksum mismatch or inter-byte
// timeout; drops are counted in a saturating error counter.
module rgbw_frame_parser #(
  parameter int             N_CH     = 7,
  parameter int             DW       = 8,
  parameter logic [DW-1:0]  SYNC     = 8'h55,
  parameter int             USE_CSUM = 1,
  parameter int             TMO_CYC  = 4096,
  parameter int             ERR_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               rdy,
  input  logic [DW-1:0]      rx_byte,
  output logic [N_CH*DW-1:0] ch_out,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               busy
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM} state_t;

  state_t             state_reg, state_next;
  logic               rdy_s1, rdy_s2, rdy_d;
  logic               ev;
  logic [IDX_W-1:0]   idx_reg;
  logic [DW-1:0]      csum_reg;
  logic [TMO_W-1:0]   tmo_reg;
  logic [DW-1:0]      shadow [N_CH];
  logic [N_CH*DW-1:0] commit_vec;
  logic               take_byte, commit, drop, last_byte, tmo_hit;

  assign ev        = rdy_s2 & ~rdy_d;
  assign last_byte = (idx_reg == IDX_W'(N_CH - 1));
  assign tmo_hit   = (tmo_reg == TMO_W'(TMO_CYC - 1));
  assign busy      = (state_reg != HUNT);

  // Commit image: when committing straight from PAYLOAD the final byte is
  // still on rx_byte, so it bypasses the shadow register.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_commit
      if (gi == N_CH - 1) begin : g_last
        assign commit_vec[gi*DW +: DW] = (state_reg == PAYLOAD) ? rx_byte : shadow[gi];
      end else begin : g_mid
        assign commit_vec[gi*DW +: DW] = shadow[gi];
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state_reg <= HUNT;
    else if (clk_en) state_reg <= state_next;
  end

  // Next-state and per-cycle control: a byte edge always beats a timeout.
  always_comb begin
    state_next = state_reg;
    take_byte  = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      HUNT: begin
        if (ev && rx_byte == SYNC) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (ev) begin
          take_byte = 1'b1;
          if (last_byte) begin
            if (USE_CSUM != 0) begin
              state_next = CSUM;
            end else begin
              commit     = 1'b1;
              state_next = HUNT;
            end
          end
        end else if (tmo_hit) begin
          drop       = 1'b1;
          state_next = HUNT;
        end
      end
      CSUM: begin
        if (ev) begin
          if (rx_byte == csum_reg) commit = 1'b1;
          else                     drop   = 1'b1;
          state_next = HUNT;
        end else if (tmo_hit) begin
          drop       = 1'b1;
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // Synchroniser, payload collection, timeout, outputs and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_s1      <= 1'b0;
      rdy_s2      <= 1'b0;
      rdy_d       <= 1'b0;
      idx_reg     <= '0;
      csum_reg    <= '0;
      tmo_reg     <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
      for (int k = 0; k < N_CH; k++) shadow[k] <= '0;
    end else if (clk_en) begin
      rdy_s1      <= rdy;
      rdy_s2      <= rdy_s1;
      rdy_d       <= rdy_s2;
      frame_valid <= commit;
      frame_err   <= drop;
      if (drop && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
      if (commit) ch_out <= commit_vec;
      if (state_reg == HUNT) begin
        idx_reg  <= '0;
        csum_reg <= '0;
      end else if (take_byte) begin
        shadow[idx_reg] <= rx_byte;
        csum_reg        <= csum_reg ^ rx_byte;
        idx_reg         <= idx_reg + IDX_W'(1);
      end
      if (state_reg == HUNT || ev || tmo_hit) tmo_reg <= '0;
      else                                    tmo_reg <= tmo_reg + TMO_W'(1);
    end
  end

endmodule
